// File: rtl/alu_ctrl_ram.sv
// Single-cycle datapath helper: instruction decoder, 32-bit ALU and a 1024x32
// RAM with asynchronous read. Only the RAM contents are state.
module alu_ctrl_ram (
    input  logic        clk,
    input  logic        rst,
    // decoder
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [4:0]  mf,
    output logic [3:0]  ctr_aluop,
    output logic        ctr_rf_dst,
    output logic        ctr_rf_we,
    output logic        ctr_branch,
    output logic        ctr_jump,
    output logic        ctr_mem_we,
    output logic        ctr_mem_to_reg,
    output logic        ctr_alu_src,
    output logic        ctr_shift,
    output logic        ctr_branch_eq,
    output logic        ctr_branch_leq,
    output logic        ctr_jump_reg,
    output logic        ctr_jal,
    output logic        ctr_sys,
    output logic        ctr_shift_var,
    output logic        ctr_load_imm,
    output logic        ctr_store_half,
    output logic        ctr_exce_ret,
    output logic        ctr_mfc0,
    output logic        ctr_mtc0,
    // ALU
    input  logic [31:0] alu_x,
    input  logic [31:0] alu_y,
    input  logic [3:0]  alu_op,
    output logic [31:0] alu_r1,
    output logic [31:0] alu_r2,
    output logic        alu_eq,
    // RAM
    input  logic [9:0]  ram_addr,
    input  logic [31:0] ram_din,
    input  logic        ram_we,
    output logic [31:0] ram_dout
);

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRA  = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_DIV  = 4'd4;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    always_comb begin
        ctr_aluop      = 4'd0;
        ctr_rf_dst     = 1'b0;
        ctr_rf_we      = 1'b0;
        ctr_branch     = 1'b0;
        ctr_jump       = 1'b0;
        ctr_mem_we     = 1'b0;
        ctr_mem_to_reg = 1'b0;
        ctr_alu_src    = 1'b0;
        ctr_shift      = 1'b0;
        ctr_branch_eq  = 1'b0;
        ctr_branch_leq = 1'b0;
        ctr_jump_reg   = 1'b0;
        ctr_jal        = 1'b0;
        ctr_sys        = 1'b0;
        ctr_shift_var  = 1'b0;
        ctr_load_imm   = 1'b0;
        ctr_store_half = 1'b0;
        ctr_exce_ret   = 1'b0;
        ctr_mfc0       = 1'b0;
        ctr_mtc0       = 1'b0;
        case (op)
            6'h00: begin
                // R-type ALU ops write rd; jr/syscall are handled below and
                // clear the register-file controls again.
                ctr_rf_dst = 1'b1;
                ctr_rf_we  = 1'b1;
                case (funct)
                    6'h20, 6'h21: ctr_aluop = ALU_ADD;
                    6'h22:        ctr_aluop = ALU_SUB;
                    6'h24:        ctr_aluop = ALU_AND;
                    6'h25:        ctr_aluop = ALU_OR;
                    6'h27:        ctr_aluop = ALU_NOR;
                    6'h2A:        ctr_aluop = ALU_SLT;
                    6'h2B:        ctr_aluop = ALU_SLTU;
                    6'h00: begin
                        ctr_aluop = ALU_SLL;
                        ctr_shift = 1'b1;
                    end
                    6'h03: begin
                        ctr_aluop = ALU_SRA;
                        ctr_shift = 1'b1;
                    end
                    6'h02: begin
                        ctr_aluop = ALU_SRL;
                        ctr_shift = 1'b1;
                    end
                    6'h04: begin
                        ctr_aluop     = ALU_SLL;
                        ctr_shift     = 1'b1;
                        ctr_shift_var = 1'b1;
                    end
                    6'h08: begin
                        ctr_rf_dst   = 1'b0;
                        ctr_rf_we    = 1'b0;
                        ctr_jump_reg = 1'b1;
                    end
                    6'h0C: begin
                        ctr_rf_dst = 1'b0;
                        ctr_rf_we  = 1'b0;
                        ctr_sys    = 1'b1;
                    end
                    default: begin
                        ctr_rf_dst = 1'b0;
                        ctr_rf_we  = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09: begin
                ctr_aluop   = ALU_ADD;
                ctr_alu_src = 1'b1;
                ctr_rf_we   = 1'b1;
            end
            6'h0C: begin
                ctr_aluop   = ALU_AND;
                ctr_alu_src = 1'b1;
                ctr_rf_we   = 1'b1;
            end
            6'h0D: begin
                ctr_aluop   = ALU_OR;
                ctr_alu_src = 1'b1;
                ctr_rf_we   = 1'b1;
            end
            6'h0A: begin
                ctr_aluop   = ALU_SLT;
                ctr_alu_src = 1'b1;
                ctr_rf_we   = 1'b1;
            end
            6'h0F: begin
                ctr_load_imm = 1'b1;
                ctr_rf_we    = 1'b1;
            end
            6'h23: begin
                ctr_aluop      = ALU_ADD;
                ctr_alu_src    = 1'b1;
                ctr_mem_to_reg = 1'b1;
                ctr_rf_we      = 1'b1;
            end
            6'h2B: begin
                ctr_aluop   = ALU_ADD;
                ctr_alu_src = 1'b1;
                ctr_mem_we  = 1'b1;
            end
            6'h29: begin
                ctr_aluop      = ALU_ADD;
                ctr_alu_src    = 1'b1;
                ctr_mem_we     = 1'b1;
                ctr_store_half = 1'b1;
            end
            6'h04: begin
                ctr_branch    = 1'b1;
                ctr_branch_eq = 1'b1;
            end
            6'h05: ctr_branch = 1'b1;
            6'h06: begin
                ctr_branch     = 1'b1;
                ctr_branch_leq = 1'b1;
            end
            6'h02: ctr_jump = 1'b1;
            6'h03: begin
                ctr_jump  = 1'b1;
                ctr_jal   = 1'b1;
                ctr_rf_we = 1'b1;
            end
            6'h10: begin
                if (mf == 5'h00) begin
                    ctr_mfc0  = 1'b1;
                    ctr_rf_we = 1'b1;
                end else if (mf == 5'h04) begin
                    ctr_mtc0 = 1'b1;
                end else if (mf == 5'h10 && funct == 6'h18) begin
                    ctr_exce_ret = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [63:0] mul_full;
    logic [31:0] div_q;
    logic [31:0] div_r;

    assign mul_full = $signed({{32{alu_x[31]}}, alu_x}) * $signed({{32{alu_y[31]}}, alu_y});
    assign alu_eq   = (alu_x == alu_y);

    always_comb begin
        div_q = 32'd0;
        div_r = 32'd0;
        if (alu_y == 32'd0) begin
            div_q = 32'd0;
            div_r = 32'd0;
        end else if (alu_x == 32'h8000_0000 && alu_y == 32'hFFFF_FFFF) begin
            // The only overflowing case: quotient wraps to the dividend.
            div_q = alu_x;
            div_r = 32'd0;
        end else begin
            div_q = $signed(alu_x) / $signed(alu_y);
            div_r = $signed(alu_x) % $signed(alu_y);
        end
    end

    always_comb begin
        alu_r1 = 32'd0;
        alu_r2 = 32'd0;
        case (alu_op)
            ALU_SLL:  alu_r1 = alu_x << alu_y[4:0];
            ALU_SRA:  alu_r1 = $signed(alu_x) >>> alu_y[4:0];
            ALU_SRL:  alu_r1 = alu_x >> alu_y[4:0];
            ALU_MUL: begin
                alu_r1 = mul_full[31:0];
                alu_r2 = mul_full[63:32];
            end
            ALU_DIV: begin
                alu_r1 = div_q;
                alu_r2 = div_r;
            end
            ALU_ADD:  alu_r1 = alu_x + alu_y;
            ALU_SUB:  alu_r1 = alu_x - alu_y;
            ALU_AND:  alu_r1 = alu_x & alu_y;
            ALU_OR:   alu_r1 = alu_x | alu_y;
            ALU_XOR:  alu_r1 = alu_x ^ alu_y;
            ALU_NOR:  alu_r1 = ~(alu_x | alu_y);
            ALU_SLT:  alu_r1 = {31'd0, $signed(alu_x) < $signed(alu_y)};
            ALU_SLTU: alu_r1 = {31'd0, alu_x < alu_y};
            default: begin
                alu_r1 = 32'd0;
                alu_r2 = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM: whole-array clear on reset rules out a block RAM, so this is a
    // register file with asynchronous read.
    // ------------------------------------------------------------------
    logic [31:0] mem_reg [1024];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) begin
                mem_reg[i] <= 32'd0;
            end
        end else if (ram_we) begin
            mem_reg[ram_addr] <= ram_din;
        end
    end

    assign ram_dout = mem_reg[ram_addr];

endmodule

// File: tb/tb_alu_ctrl_ram.sv
// Directed bench for alu_ctrl_ram: decoder vectors, ALU vectors and RAM
// write/reset sequences, each checked against hand-computed values.
module tb_alu_ctrl_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  mf;
    logic [3:0]  ctr_aluop;
    logic        ctr_rf_dst, ctr_rf_we, ctr_branch, ctr_jump, ctr_mem_we;
    logic        ctr_mem_to_reg, ctr_alu_src, ctr_shift, ctr_branch_eq;
    logic        ctr_branch_leq, ctr_jump_reg, ctr_jal, ctr_sys, ctr_shift_var;
    logic        ctr_load_imm, ctr_store_half, ctr_exce_ret, ctr_mfc0, ctr_mtc0;
    logic [31:0] alu_x, alu_y;
    logic [3:0]  alu_op;
    logic [31:0] alu_r1, alu_r2;
    logic        alu_eq;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    alu_ctrl_ram dut (
        .clk(clk), .rst(rst),
        .op(op), .funct(funct), .mf(mf),
        .ctr_aluop(ctr_aluop),
        .ctr_rf_dst(ctr_rf_dst), .ctr_rf_we(ctr_rf_we), .ctr_branch(ctr_branch),
        .ctr_jump(ctr_jump), .ctr_mem_we(ctr_mem_we), .ctr_mem_to_reg(ctr_mem_to_reg),
        .ctr_alu_src(ctr_alu_src), .ctr_shift(ctr_shift), .ctr_branch_eq(ctr_branch_eq),
        .ctr_branch_leq(ctr_branch_leq), .ctr_jump_reg(ctr_jump_reg), .ctr_jal(ctr_jal),
        .ctr_sys(ctr_sys), .ctr_shift_var(ctr_shift_var), .ctr_load_imm(ctr_load_imm),
        .ctr_store_half(ctr_store_half), .ctr_exce_ret(ctr_exce_ret),
        .ctr_mfc0(ctr_mfc0), .ctr_mtc0(ctr_mtc0),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_eq(alu_eq),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    // Control word: aluop in [22:19], flags in [18:0] in the order below.
    localparam logic [31:0] F_RF_DST     = 32'h1 << 18;
    localparam logic [31:0] F_RF_WE      = 32'h1 << 17;
    localparam logic [31:0] F_BRANCH     = 32'h1 << 16;
    localparam logic [31:0] F_JUMP       = 32'h1 << 15;
    localparam logic [31:0] F_MEM_WE     = 32'h1 << 14;
    localparam logic [31:0] F_MEM_TO_REG = 32'h1 << 13;
    localparam logic [31:0] F_ALU_SRC    = 32'h1 << 12;
    localparam logic [31:0] F_SHIFT      = 32'h1 << 11;
    localparam logic [31:0] F_BRANCH_EQ  = 32'h1 << 10;
    localparam logic [31:0] F_BRANCH_LEQ = 32'h1 << 9;
    localparam logic [31:0] F_JUMP_REG   = 32'h1 << 8;
    localparam logic [31:0] F_JAL        = 32'h1 << 7;
    localparam logic [31:0] F_SYS        = 32'h1 << 6;
    localparam logic [31:0] F_SHIFT_VAR  = 32'h1 << 5;
    localparam logic [31:0] F_LOAD_IMM   = 32'h1 << 4;
    localparam logic [31:0] F_STORE_HALF = 32'h1 << 3;
    localparam logic [31:0] F_EXCE_RET   = 32'h1 << 2;
    localparam logic [31:0] F_MFC0       = 32'h1 << 1;
    localparam logic [31:0] F_MTC0       = 32'h1 << 0;

    function automatic logic [31:0] aluop_field(input int code);
        return 32'(code) << 19;
    endfunction

    logic [31:0] ctrl_word;
    assign ctrl_word = {9'd0, ctr_aluop,
                        ctr_rf_dst, ctr_rf_we, ctr_branch, ctr_jump, ctr_mem_we,
                        ctr_mem_to_reg, ctr_alu_src, ctr_shift, ctr_branch_eq,
                        ctr_branch_leq, ctr_jump_reg, ctr_jal, ctr_sys, ctr_shift_var,
                        ctr_load_imm, ctr_store_half, ctr_exce_ret, ctr_mfc0, ctr_mtc0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("ok   %-12s got=%08h", tag, got);
        end else begin
            $display("FAIL %-12s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic decode(input string tag, input logic [5:0] o, input logic [5:0] f,
                          input logic [4:0] m, input logic [31:0] exp);
        op = o; funct = f; mf = m;
        #1;
        check(tag, ctrl_word, exp);
    endtask

    task automatic alu(input string tag, input logic [3:0] code, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] e1, input logic [31:0] e2);
        alu_op = code; alu_x = x; alu_y = y;
        #1;
        check({tag, ".r1"}, alu_r1, e1);
        check({tag, ".r2"}, alu_r2, e2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ram_we = 1'b0; ram_addr = '0; ram_din = '0;
        op = '0; funct = '0; mf = '0; alu_x = '0; alu_y = '0; alu_op = '0;
        tick();
        rst = 1'b0;
        #1;
        // RAM cleared by reset
        check("rst.a0", ram_dout, 32'd0);
        ram_addr = 10'd5;    #1; check("rst.a5", ram_dout, 32'd0);
        ram_addr = 10'd1023; #1; check("rst.a1023", ram_dout, 32'd0);

        // Decoder
        decode("dec.lw",   6'h23, 6'h00, 5'h00, aluop_field(5) | F_ALU_SRC | F_MEM_TO_REG | F_RF_WE);
        decode("dec.sllv", 6'h00, 6'h04, 5'h00, aluop_field(0) | F_SHIFT | F_SHIFT_VAR | F_RF_DST | F_RF_WE);
        decode("dec.eret", 6'h10, 6'h18, 5'h10, F_EXCE_RET);
        decode("dec.bad",  6'h3F, 6'h00, 5'h00, 32'd0);
        decode("dec.sub",  6'h00, 6'h22, 5'h00, aluop_field(6) | F_RF_DST | F_RF_WE);
        decode("dec.sra",  6'h00, 6'h03, 5'h00, aluop_field(1) | F_SHIFT | F_RF_DST | F_RF_WE);
        decode("dec.sh",   6'h29, 6'h00, 5'h00, aluop_field(5) | F_ALU_SRC | F_MEM_WE | F_STORE_HALF);
        decode("dec.jal",  6'h03, 6'h00, 5'h00, F_JUMP | F_JAL | F_RF_WE);
        decode("dec.blez", 6'h06, 6'h00, 5'h00, F_BRANCH | F_BRANCH_LEQ);
        decode("dec.mfc0", 6'h10, 6'h00, 5'h00, F_MFC0 | F_RF_WE);
        decode("dec.mtc0", 6'h10, 6'h00, 5'h04, F_MTC0);
        decode("dec.lui",  6'h0F, 6'h00, 5'h00, F_LOAD_IMM | F_RF_WE);
        decode("dec.sys",  6'h00, 6'h0C, 5'h00, F_SYS);
        decode("dec.jr",   6'h00, 6'h08, 5'h00, F_JUMP_REG);
        decode("dec.slti", 6'h0A, 6'h00, 5'h00, aluop_field(11) | F_ALU_SRC | F_RF_WE);
        decode("dec.cp0x", 6'h10, 6'h00, 5'h10, 32'd0);
        decode("dec.rbad", 6'h00, 6'h3F, 5'h00, 32'd0);

        // ALU
        alu("mul",   4'd3,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF);
        alu("div",   4'd4,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
        alu("divn",  4'd4,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        alu("div0",  4'd4,  32'hFFFF_FFF9, 32'd0,         32'd0,         32'd0);
        alu("sra",   4'd1,  32'h8000_0000, 32'd4,         32'hF800_0000, 32'd0);
        alu("srl",   4'd2,  32'h8000_0000, 32'd4,         32'h0800_0000, 32'd0);
        alu("sll",   4'd0,  32'd1,         32'h0000_003F, 32'h8000_0000, 32'd0);
        alu("slt",   4'd11, 32'hFFFF_FFFF, 32'd1,         32'd1,         32'd0);
        alu("sltu",  4'd12, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0);
        alu("add",   4'd5,  32'hFFFF_FFFF, 32'd2,         32'd1,         32'd0);
        alu("sub",   4'd6,  32'd0,         32'd1,         32'hFFFF_FFFF, 32'd0);
        alu("and",   4'd7,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'd0);
        alu("or",    4'd8,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 32'd0);
        alu("xor",   4'd9,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 32'd0);
        alu("nor",   4'd10, 32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0);
        alu("op13",  4'd13, 32'h1234_5678, 32'h1234_5678, 32'd0,         32'd0);
        check("eq.same", {31'd0, alu_eq}, 32'd1);
        alu_x = 32'h1234_5679; #1;
        check("eq.diff", {31'd0, alu_eq}, 32'd0);

        // RAM write: old data visible until the edge
        ram_addr = 10'd5; ram_din = 32'hDEAD_BEEF; ram_we = 1'b1;
        #1;
        check("ram.pre", ram_dout, 32'd0);
        tick();
        check("ram.post", ram_dout, 32'hDEAD_BEEF);
        ram_addr = 10'd1023; ram_din = 32'hA5A5_0001;
        tick();
        ram_we = 1'b0;
        #1;
        check("ram.a1023", ram_dout, 32'hA5A5_0001);
        ram_addr = 10'd5; #1;
        check("ram.a5keep", ram_dout, 32'hDEAD_BEEF);
        ram_addr = 10'd6; #1;
        check("ram.a6", ram_dout, 32'd0);

        // Reset beats a simultaneous write
        ram_addr = 10'd5; ram_din = 32'h1234_5678; ram_we = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; ram_we = 1'b0;
        #1;
        check("rst.we5", ram_dout, 32'd0);
        ram_addr = 10'd1023; #1;
        check("rst.a1023b", ram_dout, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_ram.md
ALU_CTRL_RAM -- requirements
Module: alu_ctrl_ram

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 op  in  6  instruction[31:26]; funct  in  6  instruction[5:0]; mf  in  5  instruction[25:21].
REQ-004 ctr_aluop  out  4  ALU operation code decoded from op/funct.
REQ-005 ctr_rf_dst, ctr_rf_we, ctr_branch, ctr_jump, ctr_mem_we, ctr_mem_to_reg, ctr_alu_src, ctr_shift, ctr_branch_eq, ctr_branch_leq, ctr_jump_reg, ctr_jal, ctr_sys, ctr_shift_var, ctr_load_imm, ctr_store_half, ctr_exce_ret, ctr_mfc0, ctr_mtc0  out  1 each  decoded control flags.
REQ-006 alu_x, alu_y  in  32  ALU operands; alu_op  in  4  ALU operation select.
REQ-007 alu_r1  out  32  primary result; alu_r2  out  32  secondary result; alu_eq  out  1  alu_x==alu_y.
REQ-008 ram_addr  in  10  word address; ram_din  in  32  write data; ram_we  in  1  write enable; ram_dout  out  32  read data.

Function
REQ-009 Decoder, ALU and RAM read SHALL be purely combinational; only RAM contents are state.
REQ-010 ALU codes: 0 SLL, 1 SRA, 2 SRL, 3 MUL, 4 DIV, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 NOR, 11 SLT signed, 12 SLTU; 13-15 give r1=r2=0.
REQ-011 Shifts: alu_x shifted by alu_y[4:0]; SRA sign-fills.
REQ-012 ADD/SUB wrap modulo 2^32, no overflow flag; SLT/SLTU r1 = 32'd1 or 32'd0.
REQ-013 MUL: signed 64-bit product, r1 = low word, r2 = high word.
REQ-014 DIV: signed, r1 = quotient (truncated toward zero), r2 = remainder (sign of alu_x); alu_y==0 gives r1=r2=0.
REQ-015 alu_r2 SHALL be 0 for all codes except MUL/DIV; alu_eq independent of alu_op.
REQ-016 Decoder, op=0 (ctr_rf_dst=1, ctr_rf_we=1 unless noted): funct 0x20/0x21 ADD; 0x22 SUB; 0x24 AND; 0x25 OR; 0x27 NOR; 0x2A SLT; 0x2B SLTU; 0x00 SLL+shift; 0x03 SRA+shift; 0x02 SRL+shift; 0x04 SLL+shift+shift_var.
REQ-017 op=0, funct 0x08: jump_reg only; funct 0x0C: sys only (no rf_we).
REQ-018 op 0x08/0x09 ADD, 0x0C AND, 0x0D OR, 0x0A SLT: alu_src+rf_we; 0x0F: load_imm+rf_we.
REQ-019 op 0x23 lw: ADD, alu_src, mem_to_reg, rf_we; 0x2B sw: ADD, alu_src, mem_we; 0x29 sh: as sw plus store_half.
REQ-020 op 0x04 beq: branch+branch_eq; 0x05 bne: branch; 0x06 blez: branch+branch_leq; 0x02 j: jump; 0x03 jal: jump+jal+rf_we.
REQ-021 op 0x10: mf 0x00 mfc0+rf_we; mf 0x04 mtc0; mf 0x10 with funct 0x18 exce_ret.
REQ-022 Every flag not listed for a decode SHALL be 0, ctr_aluop=0 where unspecified; unlisted op/funct/mf produce all-zero outputs.
REQ-023 RAM: 1024x32; ram_dout = mem[ram_addr] asynchronously; write mem[ram_addr]<=ram_din on rising clk when ram_we.
REQ-024 Read of address being written shows old data until the edge, new data after.

Reset
REQ-025 rst high at a rising edge SHALL clear all 1024 RAM words to 0; rst has priority over ram_we.
REQ-026 After reset, ram_dout=0 for every address; combinational outputs unaffected by rst.

Verification
REQ-027 alu_op=3, x=-3, y=7 -> r1=32'hFFFFFFEB, r2=32'hFFFFFFFF; alu_op=4, x=-7, y=2 -> r1=-3, r2=-1; y=0 -> 0,0.
REQ-028 alu_op=1, x=32'h80000000, y=4 -> r1=32'hF8000000; alu_op=11, x=-1, y=1 -> 1; alu_op=12 same operands -> 0; x==y -> alu_eq=1.
REQ-029 op=0x23 -> aluop=5, alu_src, mem_to_reg, rf_we set, all else 0; op=0 funct=0x04 -> shift, shift_var, rf_dst, rf_we.
REQ-030 op=0x10 mf=0x10 funct=0x18 -> only exce_ret; op=0x3F -> all outputs 0.
REQ-031 Write 32'hDEADBEEF to addr 5, read addr 5 -> DEADBEEF; assert rst with ram_we=1 -> addr 5 reads 0, write suppressed.
